// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared baud codes, bit-period divisors and receiver state type
package uart_rx_pkg;

  localparam int unsigned DIV_W = 13;

  localparam logic [2:0] BAUD_9600   = 3'd0;
  localparam logic [2:0] BAUD_19200  = 3'd1;
  localparam logic [2:0] BAUD_38400  = 3'd2;
  localparam logic [2:0] BAUD_57600  = 3'd3;
  localparam logic [2:0] BAUD_115200 = 3'd4;

  // Divisor N: one bit lasts N+1 cycles of the 50 MHz clock.
  localparam logic [DIV_W-1:0] DIV_9600    = 13'd5207;
  localparam logic [DIV_W-1:0] DIV_19200   = 13'd2603;
  localparam logic [DIV_W-1:0] DIV_38400   = 13'd1301;
  localparam logic [DIV_W-1:0] DIV_57600   = 13'd867;
  localparam logic [DIV_W-1:0] DIV_115200  = 13'd433;
  localparam logic [DIV_W-1:0] DIV_DEFAULT = DIV_9600;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } rx_state_e;

  function automatic logic [DIV_W-1:0] baud_divisor(input logic [2:0] code);
    case (code)
      BAUD_9600:   baud_divisor = DIV_9600;
      BAUD_19200:  baud_divisor = DIV_19200;
      BAUD_38400:  baud_divisor = DIV_38400;
      BAUD_57600:  baud_divisor = DIV_57600;
      BAUD_115200: baud_divisor = DIV_115200;
      default:     baud_divisor = DIV_DEFAULT;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - receiver line, baud select and received-byte signals
interface uart_rx_if;
  logic [2:0] baudRate;
  logic       io_rx;
  logic [7:0] rxByte;
  logic       rxValid;
  logic       rxFrameErr;
  logic       rxBusy;

  modport slave (
    input  baudRate, io_rx,
    output rxByte, rxValid, rxFrameErr, rxBusy
  );

  modport master (
    output baudRate, io_rx,
    input  rxByte, rxValid, rxFrameErr, rxBusy
  );
endinterface

// File: rtl/uart_rx_sync_ff.sv
// rtl/uart_rx_sync_ff.sv - SYNC_STAGES flop chain for an async input, preset to 1
module sync_ff #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic nRst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      sync_q <= '1;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver, LSB first, mid-bit sampling
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input logic      clk,
  input logic      nRst,
  uart_rx_if.slave bus
);

  localparam int SETTLE_W = $clog2(SYNC_STAGES + 1);
  localparam logic [SETTLE_W-1:0] SETTLE_DONE = SETTLE_W'(SYNC_STAGES);

  logic             rxs;
  logic             start_edge;
  logic             settled;
  logic [DIV_W-1:0] half_bit;

  rx_state_e        state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       rx_byte_q, rx_byte_d;
  logic             rx_valid_q, rx_valid_d;
  logic             rx_frame_err_q, rx_frame_err_d;
  logic             rx_busy_q, rx_busy_d;
  logic             rxs_prev_q, rxs_prev_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;

  sync_ff #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .nRst (nRst),
    .d    (bus.io_rx),
    .q    (rxs)
  );

  // The edge register is held at 0 until the preset ones have flushed out of
  // the synchroniser, so a line that is already low after reset is not a start.
  assign settled    = (settle_q == SETTLE_DONE);
  assign start_edge = rxs_prev_q & ~rxs;
  assign half_bit   = div_q >> 1;

  always_comb begin
    settle_d       = settled ? settle_q : settle_q + 1'b1;
    rxs_prev_d     = settled ? rxs : 1'b0;
    state_d        = state_q;
    cnt_d          = (state_q == ST_IDLE) ? '0 : cnt_q + 13'd1;
    div_d          = div_q;
    bit_idx_d      = bit_idx_q;
    shift_d        = shift_q;
    rx_byte_d      = rx_byte_q;
    rx_valid_d     = 1'b0;
    rx_frame_err_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_edge) begin
          div_d   = baud_divisor(bus.baudRate);
          state_d = ST_START;
          cnt_d   = '0;
        end
      end
      ST_START: begin
        if (cnt_q == half_bit) begin
          cnt_d     = '0;
          bit_idx_d = 3'd0;
          state_d   = rxs ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (cnt_q == div_q) begin
          cnt_d     = '0;
          shift_d   = {rxs, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        if (cnt_q == div_q) begin
          cnt_d = '0;
          if (rxs) begin
            rx_byte_d  = shift_q;
            rx_valid_d = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            rx_frame_err_d = 1'b1;
            state_d        = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        if (rxs) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase

    rx_busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      div_q          <= DIV_DEFAULT;
      bit_idx_q      <= '0;
      shift_q        <= '0;
      rx_byte_q      <= '0;
      rx_valid_q     <= 1'b0;
      rx_frame_err_q <= 1'b0;
      rx_busy_q      <= 1'b0;
      rxs_prev_q     <= 1'b0;
      settle_q       <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      div_q          <= div_d;
      bit_idx_q      <= bit_idx_d;
      shift_q        <= shift_d;
      rx_byte_q      <= rx_byte_d;
      rx_valid_q     <= rx_valid_d;
      rx_frame_err_q <= rx_frame_err_d;
      rx_busy_q      <= rx_busy_d;
      rxs_prev_q     <= rxs_prev_d;
      settle_q       <= settle_d;
    end
  end

  assign bus.rxByte     = rx_byte_q;
  assign bus.rxValid    = rx_valid_q;
  assign bus.rxFrameErr = rx_frame_err_q;
  assign bus.rxBusy     = rx_busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx
module tb_uart_rx;

  logic clk = 1'b0;
  logic nRst;
  int   cyc = 0;

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_if bus ();

  uart_rx #(.SYNC_STAGES(2)) dut (
    .clk  (clk),
    .nRst (nRst),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0] vq_byte[$];
  int         vq_time[$];
  int         eq_time[$];
  int         overlap    = 0;
  int         long_pulse = 0;
  logic       prev_v     = 1'b0;
  logic       prev_e     = 1'b0;

  always @(negedge clk) begin
    if (bus.rxValid) begin
      vq_byte.push_back(bus.rxByte);
      vq_time.push_back(cyc);
    end
    if (bus.rxFrameErr) eq_time.push_back(cyc);
    if (bus.rxValid && bus.rxFrameErr) overlap++;
    if ((bus.rxValid && prev_v) || (bus.rxFrameErr && prev_e)) long_pulse++;
    prev_v = bus.rxValid;
    prev_e = bus.rxFrameErr;
  end

  initial begin
    repeat (120000) @(posedge clk);
    $display("FAIL watchdog: cycle budget expired");
    $fatal(1, "watchdog");
  end

  // Cycles per bit at each baud code.
  function automatic int bit_cycles(input int code);
    case (code)
      1:       return 2604;
      2:       return 1302;
      3:       return 868;
      4:       return 434;
      default: return 5208;
    endcase
  endfunction

  // Sync delay + edge register, half a bit into start, then 8 data bits and the stop bit.
  function automatic int latency(input int code);
    int n;
    n = bit_cycles(code) - 1;
    return 3 + (n / 2 + 1) + 9 * (n + 1);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_near(input string name, input int act, input int exp, input int tol);
    total++;
    if (act < exp - tol || act > exp + tol) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d +/- %0d", name, act, exp, tol);
    end
  endtask

  task automatic clear_q();
    vq_byte.delete();
    vq_time.delete();
    eq_time.delete();
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Ideal transmitter; timing always follows 'code', while baudRate may be changed at chg_bit.
  task automatic send_frame(input logic [7:0] b, input int code, input logic stop,
                            input int chg_bit, input logic [2:0] chg_code, output int fall);
    int bt;
    bt = bit_cycles(code);
    bus.io_rx = 1'b0;
    fall = cyc;
    wait_cycles(bt);
    for (int i = 0; i < 8; i++) begin
      bus.io_rx = b[i];
      if (i == chg_bit) bus.baudRate = chg_code;
      wait_cycles(bt);
    end
    bus.io_rx = stop;
    if (stop) wait_cycles(bt);
  endtask

  task automatic expect_one(input string tag, input logic [7:0] b, input int fall, input int code);
    chk({tag, " valid count"}, vq_byte.size(), 1);
    chk({tag, " frame errs"}, eq_time.size(), 0);
    if (vq_byte.size() > 0) begin
      chk({tag, " byte"}, int'(vq_byte[0]), int'(b));
      chk_near({tag, " latency"}, vq_time[0] - fall, latency(code), 1);
    end
    chk({tag, " rxByte held"}, int'(bus.rxByte), int'(b));
  endtask

  typedef struct {
    int code;
    int low;
    int exp_busy;
  } glitch_t;

  typedef struct {
    int         code;
    logic [7:0] data;
  } frame_t;

  glitch_t gv[7];
  frame_t  fv[3];

  initial begin
    int         fall, fall2, busy, rise, t_drop;
    logic [7:0] rb;

    gv[0] = '{0, 1000, 2604};
    gv[1] = '{1, 500, 1302};
    gv[2] = '{2, 300, 651};
    gv[3] = '{3, 200, 434};
    gv[4] = '{4, 100, 217};
    gv[5] = '{5, 1000, 2604};
    gv[6] = '{7, 1000, 2604};
    fv[0] = '{4, 8'h55};
    fv[1] = '{4, 8'hC3};
    fv[2] = '{3, 8'hC3};

    bus.io_rx    = 1'b1;
    bus.baudRate = 3'd0;
    nRst         = 1'b0;
    wait_cycles(3);
    chk("reset rxByte", int'(bus.rxByte), 0);
    chk("reset rxValid", int'(bus.rxValid), 0);
    chk("reset rxFrameErr", int'(bus.rxFrameErr), 0);
    chk("reset rxBusy", int'(bus.rxBusy), 0);
    nRst = 1'b1;
    wait_cycles(5);

    // Short low pulses: busy for exactly H+1 cycles, no strobe.
    for (int g = 0; g < 7; g++) begin
      bus.baudRate = 3'(gv[g].code);
      clear_q();
      busy = 0;
      bus.io_rx = 1'b0;
      for (int i = 0; i < gv[g].exp_busy + 40; i++) begin
        @(negedge clk);
        if (i == gv[g].low - 1) bus.io_rx = 1'b1;
        if (bus.rxBusy) busy++;
      end
      chk($sformatf("glitch busy code%0d", gv[g].code), busy, gv[g].exp_busy);
      chk($sformatf("glitch strobes code%0d", gv[g].code), vq_byte.size() + eq_time.size(), 0);
    end

    for (int f = 0; f < 3; f++) begin
      bus.baudRate = 3'(fv[f].code);
      clear_q();
      send_frame(fv[f].data, fv[f].code, 1'b1, -1, 3'd0, fall);
      expect_one($sformatf("frame%0d", f), fv[f].data, fall, fv[f].code);
    end

    // Stop bit low, line held low, then released.
    bus.baudRate = 3'd4;
    clear_q();
    send_frame(8'h3C, 4, 1'b0, -1, 3'd0, fall);
    wait_cycles(2000);
    bus.io_rx = 1'b1;
    rise = cyc;
    t_drop = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!bus.rxBusy && t_drop < 0) t_drop = cyc;
    end
    chk("ferr count", eq_time.size(), 1);
    chk("ferr no valid", vq_byte.size(), 0);
    if (eq_time.size() > 0) chk_near("ferr latency", eq_time[0] - fall, latency(4), 1);
    chk("ferr rxByte kept", int'(bus.rxByte), 8'hC3);
    chk_near("break busy release", t_drop - rise, 3, 1);
    wait_cycles(434);
    clear_q();
    send_frame(8'h81, 4, 1'b1, -1, 3'd0, fall);
    expect_one("after break", 8'h81, fall, 4);

    // Back-to-back frames with a single stop bit.
    clear_q();
    send_frame(8'h00, 4, 1'b1, -1, 3'd0, fall);
    send_frame(8'hFF, 4, 1'b1, -1, 3'd0, fall2);
    chk("b2b count", vq_byte.size(), 2);
    if (vq_byte.size() == 2) begin
      chk("b2b first", int'(vq_byte[0]), 8'h00);
      chk("b2b second", int'(vq_byte[1]), 8'hFF);
      chk_near("b2b spacing", vq_time[1] - vq_time[0], 10 * bit_cycles(4), 1);
      chk_near("b2b second latency", vq_time[1] - fall2, latency(4), 1);
    end

    // baudRate moves to 9600 during bit 3; frame stays at the latched 115200.
    clear_q();
    send_frame(8'h96, 4, 1'b1, 3, 3'd0, fall);
    expect_one("baud change", 8'h96, fall, 4);
    bus.baudRate = 3'd4;

    for (int r = 0; r < 3; r++) begin
      rb = 8'($urandom_range(0, 255));
      clear_q();
      send_frame(rb, 4, 1'b1, -1, 3'd0, fall);
      expect_one($sformatf("random%0d", r), rb, fall, 4);
    end

    // Reset during data bit 4 with the line low.
    clear_q();
    bus.io_rx = 1'b0;
    wait_cycles(5 * 434 + 217);
    nRst = 1'b0;
    #1;
    chk("midreset rxByte", int'(bus.rxByte), 0);
    chk("midreset rxValid", int'(bus.rxValid), 0);
    chk("midreset rxFrameErr", int'(bus.rxFrameErr), 0);
    chk("midreset rxBusy", int'(bus.rxBusy), 0);
    wait_cycles(5);
    nRst = 1'b1;
    busy = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (bus.rxBusy) busy++;
    end
    chk("low after reset busy", busy, 0);
    bus.io_rx = 1'b1;
    wait_cycles(434);
    chk("no spurious strobe", vq_byte.size() + eq_time.size(), 0);
    clear_q();
    send_frame(8'h7E, 4, 1'b1, -1, 3'd0, fall);
    expect_one("post reset", 8'h7E, fall, 4);

    chk("strobe overlap", overlap, 0);
    chk("strobe width", long_pulse, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
